// File: rtl/multi_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_pkg
// Description : Shared types and constants for the gen2 multi-cycle core:
//               the FSM state enum, the opcode enum, instruction field
//               positions and register-file geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_cycle_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;

    // Instruction field positions within the decoded low 16 bits
    localparam int c_op_msb   = 15;
    localparam int c_op_lsb   = 12;
    localparam int c_rd_msb   = 11;
    localparam int c_rd_lsb   = 9;
    localparam int c_rs1_msb  = 8;
    localparam int c_rs1_lsb  = 6;
    localparam int c_rs2_msb  = 5;
    localparam int c_rs2_lsb  = 3;
    localparam int c_imm6_msb = 5;
    localparam int c_imm9_msb = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_ADDI = 4'd6,
        OP_LI   = 4'd7,
        OP_BEQZ = 4'd8,
        OP_OUT  = 4'd9,
        OP_HALT = 4'd15
    } opcode_t;

    // True for opcodes that write their result into rd
    function automatic logic op_writes_rd(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_cycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_alu
// Description : Purely combinational ALU. ADD/ADDI add, LI passes b, OUT
//               passes a through so writeback can take res from the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_alu
    import multi_cycle_pkg::*;
#(
    parameter int DATA_LEN = 16
) (
    input  logic [3:0]          i_op,
    input  logic [DATA_LEN-1:0] i_a,
    input  logic [DATA_LEN-1:0] i_b,
    output logic [DATA_LEN-1:0] o_result
);

    // Opcode-selected result, modulo 2^DATA_LEN
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD, OP_ADDI: o_result = i_a + i_b;
            OP_SUB:          o_result = i_a - i_b;
            OP_AND:          o_result = i_a & i_b;
            OP_OR:           o_result = i_a | i_b;
            OP_XOR:          o_result = i_a ^ i_b;
            OP_LI:           o_result = i_b;
            OP_OUT:          o_result = i_a;
            default:         o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_core_gen2.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_core_gen2
// Description : Second-generation multi-cycle core. FETCH/DECODE/EXECUTE/
//               WRITEBACK FSM, 8-entry register file (R0 hard zero),
//               programmable instruction memory, registered res output with
//               a one-cycle valid strobe, start/halt control and BEQZ branch.
//               Optional macro CYCLE_COUNTER_EN adds the cycle_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_core_gen2
    import multi_cycle_pkg::*;
#(
    parameter int INSTRUCTION_LEN      = 16,
    parameter int INSTRUCTION_MEM_SIZE = 8,
    parameter int DATA_LEN             = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    prog_we,
    input  logic [$clog2(INSTRUCTION_MEM_SIZE)-1:0] prog_addr,
    input  logic [INSTRUCTION_LEN-1:0]              prog_data,
    input  logic                                    start,
    output logic [DATA_LEN-1:0]                     res,
    output logic                                    res_valid,
    output logic                                    halted,
    output logic                                    busy
`ifdef CYCLE_COUNTER_EN
    ,
    output logic [31:0]                             cycle_count
`endif
);

    localparam int c_pc_w = $clog2(INSTRUCTION_MEM_SIZE);
    localparam logic [c_pc_w-1:0] c_pc_one = 1;

    state_t                     r_state;
    logic [c_pc_w-1:0]          r_pc;
    logic [15:0]                r_ir;
    logic [DATA_LEN-1:0]        r_regs [NUM_REGS];
    logic [DATA_LEN-1:0]        r_a;
    logic [DATA_LEN-1:0]        r_b;
    logic [DATA_LEN-1:0]        r_alu;
    logic [DATA_LEN-1:0]        r_res;
    logic                       r_res_valid;
    logic                       r_halted;
    logic                       r_busy;
    logic [INSTRUCTION_LEN-1:0] r_imem [INSTRUCTION_MEM_SIZE];

    logic [3:0]                 w_op;
    logic [REG_IDX_W-1:0]       w_rd;
    logic [REG_IDX_W-1:0]       w_rs1;
    logic [REG_IDX_W-1:0]       w_rs2;
    logic [DATA_LEN-1:0]        w_imm6_ext;
    logic [DATA_LEN-1:0]        w_imm9_ext;
    logic [DATA_LEN-1:0]        w_alu_result;
    logic [INSTRUCTION_LEN-1:0] w_fetch_word;
    logic [c_pc_w-1:0]          w_br_off;
    logic [c_pc_w-1:0]          w_br_tgt;
    logic                       w_idle_like;

    assign w_op        = r_ir[c_op_msb:c_op_lsb];
    assign w_rd        = r_ir[c_rd_msb:c_rd_lsb];
    assign w_rs1       = r_ir[c_rs1_msb:c_rs1_lsb];
    assign w_rs2       = r_ir[c_rs2_msb:c_rs2_lsb];
    assign w_imm6_ext  = DATA_LEN'($signed(r_ir[c_imm6_msb:0]));
    assign w_imm9_ext  = DATA_LEN'($signed(r_ir[c_imm9_msb:0]));
    assign w_fetch_word = r_imem[r_pc];
    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_HALTED);

    // Only the low 16 instruction bits are decoded; wider words are tolerated
    generate
        if (INSTRUCTION_LEN > 16) begin : g_ir_upper
            logic w_unused_ir_upper;
            assign w_unused_ir_upper = &{1'b0, w_fetch_word[INSTRUCTION_LEN-1:16]};
        end
    endgenerate

    // Branch offset sign-extended (or truncated) to pc width; pc wraps
    generate
        if (c_pc_w <= 6) begin : g_br_off_narrow
            assign w_br_off = r_ir[c_pc_w-1:0];
        end else begin : g_br_off_wide
            assign w_br_off = {{(c_pc_w-6){r_ir[5]}}, r_ir[5:0]};
        end
    endgenerate

    assign w_br_tgt = r_pc + c_pc_one + w_br_off;

    multi_cycle_alu #(
        .DATA_LEN (DATA_LEN)
    ) u_alu (
        .i_op     (w_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result)
    );

    // Program load; only honoured while the core is not executing
    always_ff @(posedge clk) begin
        if (prog_we && w_idle_like) begin
            r_imem[prog_addr] <= prog_data;
        end
    end

    // Main FSM with registered status outputs and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_alu       <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_halted    <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_state  <= ST_FETCH;
                        r_pc     <= '0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= w_fetch_word[15:0];
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (w_op == OP_HALT) begin
                        r_state  <= ST_HALTED;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        // BEQZ tests rd, everything else reads rs1
                        r_a <= (w_op == OP_BEQZ) ? r_regs[w_rd] : r_regs[w_rs1];
                        case (w_op)
                            OP_ADDI: r_b <= w_imm6_ext;
                            OP_LI:   r_b <= w_imm9_ext;
                            default: r_b <= r_regs[w_rs2];
                        endcase
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    r_alu   <= w_alu_result;
                    r_state <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    // R0 is never written so it always reads as zero
                    if (op_writes_rd(w_op) && (w_rd != '0)) begin
                        r_regs[w_rd] <= r_alu;
                    end
                    if ((w_op == OP_BEQZ) && (r_a == '0)) begin
                        r_pc <= w_br_tgt;
                    end else begin
                        r_pc <= r_pc + c_pc_one;
                    end
                    if (w_op == OP_OUT) begin
                        r_res       <= r_alu;
                        r_res_valid <= 1'b1;
                    end
                    r_state <= ST_FETCH;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign halted    = r_halted;
    assign busy      = r_busy;

`ifdef CYCLE_COUNTER_EN
    logic [31:0] r_cycle_count;

    // Saturating count of busy cycles, restarted by each accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count <= '0;
        end else if (w_idle_like && start) begin
            r_cycle_count <= '0;
        end else if (!w_idle_like && (r_cycle_count != 32'hFFFF_FFFF)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_core_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_cycle_core_gen2
// Description : Self-checking bench for multi_cycle_core_gen2. An ISA-level
//               interpreter predicts OUT values, final state and run length;
//               a monitor pops expected res values on every strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_cycle_core_gen2;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [15:0] prog_data;
    logic        start;
    logic [15:0] res;
    logic        res_valid;
    logic        halted;
    logic        busy;
`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_count;
`endif

    always #5 clk = ~clk;

    multi_cycle_core_gen2 #(
        .INSTRUCTION_LEN      (16),
        .INSTRUCTION_MEM_SIZE (8),
        .DATA_LEN             (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .res       (res),
        .res_valid (res_valid),
        .halted    (halted),
        .busy      (busy)
`ifdef CYCLE_COUNTER_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          last_strobe = -1;
    logic [15:0] prog [8];
    logic [15:0] m_regs [8];
    logic [15:0] m_res;
    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rd, input int rs1, input int imm);
        return {4'(op), 3'(rd), 3'(rs1), 6'(imm)};
    endfunction

    function automatic logic [15:0] enc_li(input int rd, input int imm);
        return {4'd7, 3'(rd), 9'(imm)};
    endfunction

    function automatic void setr(input int rd, input logic [15:0] v);
        if (rd != 0) m_regs[rd] = v;
    endfunction

    // ISA interpreter: returns executed non-HALT instruction count, -1 if no halt
    function automatic int model_run();
        int pc, n, nxt, rd, rs1, rs2;
        logic [15:0] w;
        logic [3:0]  op;
        pc = 0;
        n  = 0;
        for (int s = 0; s < 1000; s++) begin
            w   = prog[pc];
            op  = w[15:12];
            rd  = int'(w[11:9]);
            rs1 = int'(w[8:6]);
            rs2 = int'(w[5:3]);
            if (op == 4'd15) return n;
            n++;
            nxt = (pc + 1) % 8;
            case (op)
                4'd1: setr(rd, m_regs[rs1] + m_regs[rs2]);
                4'd2: setr(rd, m_regs[rs1] - m_regs[rs2]);
                4'd3: setr(rd, m_regs[rs1] & m_regs[rs2]);
                4'd4: setr(rd, m_regs[rs1] | m_regs[rs2]);
                4'd5: setr(rd, m_regs[rs1] ^ m_regs[rs2]);
                4'd6: setr(rd, m_regs[rs1] + 16'($signed(w[5:0])));
                4'd7: setr(rd, 16'($signed(w[8:0])));
                4'd8: if (m_regs[rd] == 16'd0) nxt = (pc + 1 + int'($signed(w[5:0]))) & 7;
                4'd9: begin
                    m_res = m_regs[rs1];
                    exp_q.push_back(m_res);
                end
                default: ;
            endcase
            pc = nxt;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: every strobe must match the next predicted OUT value
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL res_unexpected: got strobe with res %0h expected no strobe", res);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("res_value", {16'd0, res}, {16'd0, mon_exp});
            end
            if (last_strobe >= 0) chk("strobe_gap_ge4", 32'(cyc - last_strobe >= 4), 32'd1);
            last_strobe = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
        m_res = 16'd0;
        exp_q.delete();
        if (check) begin
            @(negedge clk);
            chk("reset_res", {16'd0, res}, 32'd0);
            chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
            chk("reset_halted", {31'd0, halted}, 32'd0);
            chk("reset_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 8; i++) begin
            prog_we   = 1'b1;
            prog_addr = 3'(i);
            prog_data = prog[i];
            tick();
        end
        prog_we = 1'b0;
    endtask

    // Start a run (optionally writing a word at the start edge), optionally
    // injecting ignored start/prog_we mid-run, then check the finished state.
    task automatic run_prog(input string nm, input bit inject, input bit wr, input int wa, input logic [15:0] wd);
        int n, cnt;
        bit done;
        if (wr) prog[wa] = wd;
        n = model_run();
        if (n < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_model: got no halt expected halt", nm);
            return;
        end
        start     = 1'b1;
        prog_we   = wr;
        prog_addr = 3'(wa);
        prog_data = wd;
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        cnt  = 0;
        done = 1'b0;
        while (!done && cnt < 2000) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cnt++;
                if (inject && cnt == 5) begin
                    start     = 1'b1;
                    prog_we   = 1'b1;
                    prog_addr = 3'd3;
                    prog_data = 16'hF000;
                end else begin
                    start   = 1'b0;
                    prog_we = 1'b0;
                end
            end
        end
        start   = 1'b0;
        prog_we = 1'b0;
        chk({nm, "_halt_cycles"}, 32'(cnt), 32'(4 * n + 2));
        chk({nm, "_halted"}, {31'd0, halted}, 32'd1);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_pending_outs"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_res_final"}, {16'd0, res}, {16'd0, m_res});
`ifdef CYCLE_COUNTER_EN
        chk({nm, "_cycle_count"}, cycle_count, 32'(4 * n + 2));
`endif
        exp_q.delete();
    endtask

    task automatic prog_basic();
        for (int i = 0; i < 8; i++) prog[i] = 16'hF000;
        prog[0] = enc_li(1, 5);
        prog[1] = enc_li(2, 7);
        prog[2] = enc_r(1, 3, 1, 2);
        prog[3] = enc_r(9, 0, 3, 0);
        prog[4] = 16'hF000;
    endtask

    initial begin
        int op;
        logic [15:0] w;
        reset     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = 3'd0;
        prog_data = 16'd0;
        start     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b1);

        // Basic ALU, then rerun from HALTED without reload
        prog_basic();
        load_prog();
        run_prog("basic", 1'b0, 1'b0, 0, 16'd0);
        chk("basic_res12", {16'd0, res}, 32'd12);
        run_prog("rerun", 1'b0, 1'b0, 0, 16'd0);
        // Write landing on the start edge is seen by the following fetch
        run_prog("wr_start", 1'b0, 1'b1, 3, enc_r(9, 0, 1, 0));
        chk("wr_start_res5", {16'd0, res}, 32'd5);

        // Wrap-around arithmetic
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) prog[i] = 16'hF000;
        prog[0] = enc_li(1, -1);
        prog[1] = enc_i(6, 2, 1, 1);
        prog[2] = enc_r(9, 0, 2, 0);
        prog[3] = enc_r(2, 3, 0, 1);
        prog[4] = enc_r(9, 0, 3, 0);
        load_prog();
        run_prog("wrap", 1'b0, 1'b0, 0, 16'd0);
        chk("wrap_res1", {16'd0, res}, 32'd1);

        // Branch loop: strobes 3, 2, 1
        do_reset(1'b0);
        prog[0] = enc_li(1, 3);
        prog[1] = enc_r(9, 0, 1, 0);
        prog[2] = enc_i(6, 1, 1, -1);
        prog[3] = enc_i(8, 1, 0, 1);
        prog[4] = enc_i(8, 0, 0, -4);
        prog[5] = 16'hF000;
        prog[6] = 16'hF000;
        prog[7] = 16'hF000;
        load_prog();
        run_prog("branch", 1'b0, 1'b0, 0, 16'd0);

        // R0 writes discarded, illegal opcode is a NOP
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) prog[i] = 16'hF000;
        prog[0] = enc_li(0, 9);
        prog[1] = enc_r(9, 0, 0, 0);
        prog[2] = 16'hC000;
        prog[3] = enc_r(9, 0, 0, 0);
        load_prog();
        run_prog("r0_illegal", 1'b0, 1'b0, 0, 16'd0);

        // Reset during EXECUTE of the ADD, then restart without reload
        do_reset(1'b0);
        prog_basic();
        load_prog();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        do_reset(1'b1);
        run_prog("after_reset", 1'b0, 1'b0, 0, 16'd0);
        chk("after_reset_res12", {16'd0, res}, 32'd12);

        // start/prog_we while busy are ignored; memory stays intact
        do_reset(1'b0);
        prog_basic();
        load_prog();
        run_prog("busy_ignore", 1'b1, 1'b0, 0, 16'd0);
        chk("busy_ignore_res12", {16'd0, res}, 32'd12);
        run_prog("busy_ignore_rerun", 1'b0, 1'b0, 0, 16'd0);

        // Randomised straight-line programs with forward branches;
        // odd iterations reload in HALTED so registers carry over
        for (int t = 0; t < 8; t++) begin
            if (t % 2 == 0) do_reset(1'b0);
            for (int p = 0; p < 7; p++) begin
                op = $urandom_range(0, 14);
                w  = 16'($urandom);
                w[15:12] = 4'(op);
                if (op == 8) w[5:0] = 6'($urandom_range(0, 6 - p));
                prog[p] = w;
            end
            prog[7] = 16'hF000;
            load_prog();
            run_prog("random", 1'b0, 1'b0, 0, 16'd0);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
